i2c_bus_arbiter: RTL and testbench

Shares one open-drain I2C bus (SCL/SDA) between up to four I2C masters, such as a one-shot configuration writer and a continuous register poller targeting the same sensor. Requesters arbitrate round-robin. Only the granted master's line-drive enables reach the pads. A guard gap is enforced between owners, and a watchdog reclaims the bus from a master that never releases it. The block sits between the masters' open-drain enables and the top-level `inout` pad drivers.

---
 rtl/i2c_bus_arbiter_if.sv | 31 +++
 rtl/i2c_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Bus-side bundle of the I2C arbiter: per-master requests, releases and
// open-drain enables in, grant/owner status and pad enables out.
interface i2c_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] req_i;
  logic [NUM_MASTERS-1:0] release_i;
  logic [NUM_MASTERS-1:0] m_scl_oe_i;
  logic [NUM_MASTERS-1:0] m_sda_oe_i;
  logic [NUM_MASTERS-1:0] grant_o;
  logic [1:0]             owner_o;
  logic                   busy_o;
  logic                   scl_oe_o;
  logic                   sda_oe_o;
  logic                   timeout_err_o;
  logic [7:0]             timeout_count_o;

  // Arbiter side
  modport slave (
    input  req_i, release_i, m_scl_oe_i, m_sda_oe_i,
    output grant_o, owner_o, busy_o, scl_oe_o, sda_oe_o,
           timeout_err_o, timeout_count_o
  );

  // Requester / environment side
  modport master (
    output req_i, release_i, m_scl_oe_i, m_sda_oe_i,
    input  grant_o, owner_o, busy_o, scl_oe_o, sda_oe_o,
           timeout_err_o, timeout_count_o
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner selection for a shared open-drain I2C bus, with a guard
// gap between owners and a watchdog that reclaims a bus never released.
module i2c_bus_arbiter #(
  parameter int          NUM_MASTERS    = 2,
  parameter int          GUARD_CYCLES   = 16,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input logic              clock,
  input logic              reset_n,
  i2c_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  localparam logic [19:0] GUARD_LAST = 20'(GUARD_CYCLES - 1);
  localparam logic [19:0] TO_LAST    = TIMEOUT_CYCLES - 20'd1;
  localparam logic [2:0]  NM3        = 3'(NUM_MASTERS);

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] req_q;
  logic [NUM_MASTERS-1:0] rel_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [1:0]             owner_q;
  logic [1:0]             last_q;
  logic [19:0]            cnt_q;
  logic                   scl_q;
  logic                   sda_q;
  logic                   terr_q;
  logic [7:0]             tcnt_q;

  logic                   pick_vld;
  logic [1:0]             pick_idx;
  logic [2:0]             cand;
  logic [NUM_MASTERS-1:0] grant_d;
  logic                   rel_hit;
  logic                   wdog_fire;

  // Round-robin pick: first requester at or after last+1, wrapping; smaller
  // offsets are visited last so they override larger ones.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= NM3) cand = cand - NM3;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (req_q[j] && (cand == 3'(j))) begin
          pick_vld = 1'b1;
          pick_idx = 2'(j);
        end
      end
    end
  end

  // One-hot of the picked master; grant_q is one-hot of the owner, so
  // masking with it both qualifies the owner's release and muxes its pads.
  always_comb begin
    grant_d = '0;
    for (int i = 0; i < NUM_MASTERS; i++) grant_d[i] = (pick_idx == 2'(i));
  end

  assign rel_hit   = |(rel_q & grant_q);
  assign wdog_fire = (TIMEOUT_CYCLES != 20'd0) && (cnt_q == TO_LAST);

  // Arbitration FSM with registered grant, pad enables and watchdog status.
  // Requests and releases pass through one register stage before the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rel_q   <= '0;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= 2'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      terr_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      req_q  <= bus.req_i;
      rel_q  <= bus.release_i;
      terr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          scl_q <= 1'b0;
          sda_q <= 1'b0;
          if (pick_vld) begin
            state_q <= GRANT;
            grant_q <= grant_d;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            cnt_q   <= '0;
            scl_q   <= |(bus.m_scl_oe_i & grant_d);
            sda_q   <= |(bus.m_sda_oe_i & grant_d);
          end
        end
        GRANT: begin
          if (rel_hit || wdog_fire) begin
            // A release on the watchdog cycle wins: no error is reported.
            state_q <= GUARD;
            grant_q <= '0;
            cnt_q   <= '0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            if (!rel_hit) begin
              terr_q <= 1'b1;
              if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
            end
          end else begin
            cnt_q <= cnt_q + 20'd1;
            scl_q <= |(bus.m_scl_oe_i & grant_q);
            sda_q <= |(bus.m_sda_oe_i & grant_q);
          end
        end
        GUARD: begin
          scl_q <= 1'b0;
          sda_q <= 1'b0;
          if (cnt_q == GUARD_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          scl_q   <= 1'b0;
          sda_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_o         = grant_q;
  assign bus.owner_o         = owner_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.scl_oe_o        = scl_q;
  assign bus.sda_oe_o        = sda_q;
  assign bus.timeout_err_o   = terr_q;
  assign bus.timeout_count_o = tcnt_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboarded bench for i2c_bus_arbiter: directed stimulus queues the
// expected grant events (value, owner, watchdog status, cycle), a monitor
// pops one per observed grant change or timeout pulse.
module tb_i2c_bus_arbiter;

  typedef struct {
    logic [1:0] grant;
    logic [1:0] owner;
    logic       terr;
    logic [7:0] tcnt;
    int         cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_tcnt = 0;
  int   g;
  int   t;
  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] prev_grant = 2'b00;

  i2c_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  i2c_bus_arbiter #(
    .NUM_MASTERS   (2),
    .GUARD_CYCLES  (16),
    .TIMEOUT_CYCLES(20'd50)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic push(input logic [1:0] gr, input logic [1:0] ow, input logic te,
                      input int tc, input int c);
    exp_t e;
    e.grant = gr; e.owner = ow; e.terr = te; e.tcnt = 8'(tc); e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic pulse_rel(input int m);
    bus.release_i = '0;
    bus.release_i[m] = 1'b1;
    tick(1);
    bus.release_i = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant change or timeout pulse must match the next queued event.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_grant = bus.grant_o;
    end else begin
      if (bus.grant_o !== prev_grant || bus.timeout_err_o !== 1'b0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: grant=%b terr=%b cycle=%0d, expected no event",
                   bus.grant_o, bus.timeout_err_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (bus.grant_o !== mon_e.grant || bus.owner_o !== mon_e.owner ||
              bus.timeout_err_o !== mon_e.terr || bus.timeout_count_o !== mon_e.tcnt ||
              cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL grant_event: got grant=%b owner=%0d terr=%b tcnt=%0d cyc=%0d, expected grant=%b owner=%0d terr=%b tcnt=%0d cyc=%0d",
                     bus.grant_o, bus.owner_o, bus.timeout_err_o, bus.timeout_count_o, cyc,
                     mon_e.grant, mon_e.owner, mon_e.terr, mon_e.tcnt, mon_e.cyc);
          end
        end
      end
      prev_grant = bus.grant_o;
    end
  end

  // Run-length bound
  initial begin
    repeat (40000) @(posedge clock);
    $display("FAIL run_bound: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "cycle budget exhausted");
  end

  initial begin
    bus.req_i = 2'b00; bus.release_i = 2'b00;
    bus.m_scl_oe_i = 2'b00; bus.m_sda_oe_i = 2'b00;
    tick(3);
    check("rst_grant",  32'(bus.grant_o), 0);
    check("rst_owner",  32'(bus.owner_o), 0);
    check("rst_busy",   32'(bus.busy_o), 0);
    check("rst_scl",    32'(bus.scl_oe_o), 0);
    check("rst_sda",    32'(bus.sda_oe_o), 0);
    check("rst_terr",   32'(bus.timeout_err_o), 0);
    check("rst_tcnt",   32'(bus.timeout_count_o), 0);

    // Both request; master 0 wins two edges after reset release.
    bus.req_i = 2'b11;
    tick(1);
    reset_n = 1'b1;
    t = cyc;
    push(2'b01, 0, 0, 0, t + 2);
    wait_cyc(t + 5);

    // Master 0 releases: clear after 2 edges, master 1 after the guard gap.
    t = cyc;
    push(2'b00, 0, 0, 0, t + 2);
    push(2'b10, 1, 0, 0, t + 19);
    pulse_rel(0);
    wait_cyc(t + 19);

    // Only the owner's enables reach the pads.
    bus.m_scl_oe_i = 2'b01;
    bus.m_sda_oe_i = 2'b10;
    tick(1);
    check("pad_sda_owner", 32'(bus.sda_oe_o), 1);
    check("pad_scl_nonowner", 32'(bus.scl_oe_o), 0);

    // Master 1 releases; pads stay low and busy stays high through the guard.
    t = cyc;
    push(2'b00, 1, 0, 0, t + 2);
    push(2'b01, 0, 0, 0, t + 19);
    pulse_rel(1);
    wait_cyc(t + 2);
    for (int i = 0; i < 16; i++) begin
      check("guard_pads", {30'd0, bus.scl_oe_o, bus.sda_oe_o}, 0);
      check("guard_busy", 32'(bus.busy_o), 1);
      tick(1);
    end
    check("idle_busy", 32'(bus.busy_o), 0);
    tick(1);
    check("grant_pad_scl", 32'(bus.scl_oe_o), 1);
    check("grant_pad_sda", 32'(bus.sda_oe_o), 0);

    // Non-owner release and dropped request do not end ownership.
    pulse_rel(1);
    bus.req_i = 2'b10;
    tick(5);
    check("hold_grant", 32'(bus.grant_o), 32'h1);
    t = cyc;
    push(2'b00, 0, 0, 0, t + 2);
    push(2'b10, 1, 0, 0, t + 19);
    pulse_rel(0);
    wait_cyc(t + 19);

    // Hand back to master 0 and let it hold the bus.
    bus.req_i = 2'b01;
    t = cyc;
    push(2'b00, 1, 0, 0, t + 2);
    push(2'b01, 0, 0, 0, t + 19);
    pulse_rel(1);
    wait_cyc(t + 19);

    // Watchdog: 300 reclaims plus one release racing the timeout.
    g = cyc;
    for (int i = 0; i <= 300; i++) begin
      if (i == 1) begin
        push(2'b00, 0, 0, exp_tcnt, g + 50);
        push(2'b01, 0, 0, exp_tcnt, g + 67);
        wait_cyc(g + 48);
        pulse_rel(0);
      end else begin
        if (exp_tcnt != 255) exp_tcnt++;
        push(2'b00, 0, 1, exp_tcnt, g + 50);
        push(2'b01, 0, 0, exp_tcnt, g + 67);
      end
      wait_cyc(g + 67);
      g = g + 67;
    end
    check("tcnt_saturated", 32'(bus.timeout_count_o), 255);

    // Asynchronous reset mid-grant.
    tick(2);
    check("pre_rst_scl", 32'(bus.scl_oe_o), 1);
    reset_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant_o), 0);
    check("async_scl",   32'(bus.scl_oe_o), 0);
    check("async_busy",  32'(bus.busy_o), 0);
    tick(2);
    reset_n = 1'b1;
    t = cyc;
    push(2'b01, 0, 0, 0, t + 2);
    wait_cyc(t + 4);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
